// File: rtl/polar_sched_pkg.sv
// Shared types for the polar decoder scheduler: FSM state encoding and index-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package polar_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Width needed to index n items; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/polar_rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters, scanning upward from ptr+1 with wrap.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: none; the caller decides whether the grant is consumed.
module polar_rr_arbiter
    import polar_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // First set request after the last-served slot wins; ptr itself is checked last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_vld && req[cand_idx]) begin
                grant_vld       = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/polar_decode_scheduler.sv
// Shares one polar decoder among NUM_REQ requesters, one block in flight; optional WAIT abort via POLAR_SCHED_TIMEOUT_EN.
// Latency: accept at t, dec_in_valid at t+1, rsp_valid no earlier than t+2+decoder latency.
// Backpressure: rsp_valid holds until rsp_ready of the granted requester; nothing new is accepted meanwhile.
module polar_decode_scheduler
    import polar_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int BITS    = 8,
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][N-1:0][BITS-1:0] req_y,
    input  logic [NUM_REQ-1:0][N-1:0]          req_frozen,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [N-1:0]                       rsp_u,
    output logic                               rsp_error,
    output logic                               dec_in_valid,
    output logic [N-1:0][BITS-1:0]             dec_y,
    output logic [N-1:0]                       dec_frozen,
    input  logic                               dec_out_valid,
    input  logic [N-1:0]                       dec_u,
    output logic [CNT_W-1:0]                   blk_count
);

    localparam int               IDX_W   = idx_w(NUM_REQ);
    // Pointer starts at the last slot so requester 0 is scanned first after reset.
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    // LLRs are two's complement; the scheduler only moves them, so no signed arithmetic here.
    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [N-1:0][BITS-1:0]   dec_y_q, dec_y_d;
    logic [N-1:0]             dec_frozen_q, dec_frozen_d;
    logic                     dec_in_valid_q, dec_in_valid_d;
    logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [N-1:0]             rsp_u_q, rsp_u_d;
    logic [CNT_W-1:0]         blk_count_q, blk_count_d;

    logic [NUM_REQ-1:0]       arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_vld;

`ifdef POLAR_SCHED_TIMEOUT_EN
    localparam int               TMO_W    = idx_w(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]            wait_cnt_q, wait_cnt_d;
    logic                        rsp_error_q, rsp_error_d;
`endif

    polar_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // Next-state logic: accept only in IDLE, so the decoder never sees a second start while busy.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        dec_y_d        = dec_y_q;
        dec_frozen_d   = dec_frozen_q;
        dec_in_valid_d = 1'b0;
        rsp_valid_d    = rsp_valid_q;
        rsp_u_d        = rsp_u_q;
        blk_count_d    = blk_count_q;
        req_ready      = '0;
`ifdef POLAR_SCHED_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        rsp_error_d    = rsp_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_vld && !rst) begin
                    req_ready      = arb_grant;
                    dec_y_d        = req_y[arb_idx];
                    dec_frozen_d   = req_frozen[arb_idx];
                    grant_d        = arb_idx;
                    dec_in_valid_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef POLAR_SCHED_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (dec_out_valid) begin
                    rsp_u_d              = dec_u;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
`ifdef POLAR_SCHED_TIMEOUT_EN
                    rsp_error_d          = 1'b0;
                end else if (wait_cnt_q == TMO_LAST) begin
                    // Decoder went silent: hand back an all-zero block flagged as aborted.
                    rsp_u_d              = '0;
                    rsp_error_d          = 1'b1;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + TMO_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    ptr_d       = grant_q;
                    blk_count_d = blk_count_q + CNT_W'(1);
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= PTR_RST;
            grant_q        <= '0;
            dec_y_q        <= '0;
            dec_frozen_q   <= '0;
            dec_in_valid_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_u_q        <= '0;
            blk_count_q    <= '0;
`ifdef POLAR_SCHED_TIMEOUT_EN
            wait_cnt_q     <= '0;
            rsp_error_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            dec_y_q        <= dec_y_d;
            dec_frozen_q   <= dec_frozen_d;
            dec_in_valid_q <= dec_in_valid_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_u_q        <= rsp_u_d;
            blk_count_q    <= blk_count_d;
`ifdef POLAR_SCHED_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            rsp_error_q    <= rsp_error_d;
`endif
        end
    end

    assign dec_y        = dec_y_q;
    assign dec_frozen   = dec_frozen_q;
    assign dec_in_valid = dec_in_valid_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_u        = rsp_u_q;
    assign blk_count    = blk_count_q;
`ifdef POLAR_SCHED_TIMEOUT_EN
    assign rsp_error    = rsp_error_q;
`else
    assign rsp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_polar_decode_scheduler.sv
// Directed bench for polar_decode_scheduler with a behavioural N=4 decoder stub.
// Expected responses are queued when blocks are loaded and checked at each response handshake.
// Timeout scenario runs only when POLAR_SCHED_TIMEOUT_EN is defined.
module tb_polar_decode_scheduler;

    localparam int N    = 4;
    localparam int BITS = 8;
    localparam int NR   = 2;
    localparam int TMO  = 8;
    localparam int CW   = 16;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          rst;
    logic [NR-1:0]                 req_valid;
    logic [NR-1:0]                 req_ready;
    logic [NR-1:0][N-1:0][BITS-1:0] req_y;
    logic [NR-1:0][N-1:0]          req_frozen;
    logic [NR-1:0]                 rsp_valid;
    logic [NR-1:0]                 rsp_ready;
    logic [N-1:0]                  rsp_u;
    logic                          rsp_error;
    logic                          dec_in_valid;
    logic [N-1:0][BITS-1:0]        dec_y;
    logic [N-1:0]                  dec_frozen;
    logic                          dec_out_valid;
    logic [N-1:0]                  dec_u;
    logic [CW-1:0]                 blk_count;

    polar_decode_scheduler #(
        .N (N), .BITS (BITS), .NUM_REQ (NR), .TIMEOUT (TMO), .CNT_W (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_y         (req_y),
        .req_frozen    (req_frozen),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_u         (rsp_u),
        .rsp_error     (rsp_error),
        .dec_in_valid  (dec_in_valid),
        .dec_y         (dec_y),
        .dec_frozen    (dec_frozen),
        .dec_out_valid (dec_out_valid),
        .dec_u         (dec_u),
        .blk_count     (blk_count)
    );

    // N=4 polar transform (self-inverse over GF(2)).
    function automatic logic [3:0] polar_xform(input logic [3:0] a);
        return {a[3], a[2] ^ a[3], a[1] ^ a[3], a[0] ^ a[1] ^ a[2] ^ a[3]};
    endfunction

    // Noiseless channel: codeword bit 0 -> +32, bit 1 -> -32.
    function automatic logic [3:0][7:0] to_llr(input logic [3:0] u);
        logic [3:0]      x;
        logic [3:0][7:0] r;
        x = polar_xform(u);
        for (int i = 0; i < 4; i++) r[i] = x[i] ? 8'hE0 : 8'h20;
        return r;
    endfunction

    function automatic logic [3:0] hard_decode(input logic [3:0][7:0] y);
        logic [3:0] x;
        for (int i = 0; i < 4; i++) x[i] = y[i][7];
        return polar_xform(x);
    endfunction

    // Decoder stub: answers LAT cycles after a start pulse when enabled.
    logic       stub_en, stub_vld, force_vld;
    logic [3:0] stub_u, pend_u, force_u;
    int         pend;

    always @(posedge clk) begin
        if (rst) begin
            stub_vld <= 1'b0;
            stub_u   <= 4'h0;
            pend     <= 0;
        end else begin
            stub_vld <= 1'b0;
            if (stub_en && dec_in_valid) begin
                pend   <= LAT;
                pend_u <= hard_decode(dec_y);
            end else if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) begin
                    stub_vld <= 1'b1;
                    stub_u   <= pend_u;
                end
            end
        end
    end

    assign dec_out_valid = stub_vld | force_vld;
    assign dec_u         = force_vld ? force_u : stub_u;

    typedef struct {
        int         rq;
        logic [3:0] u;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] src0_q[$];
    logic [3:0] src1_q[$];
    int         total = 0, passed = 0, failed = 0;
    int         cyc = 0, acc_cyc = 0, pulses = 0;
    logic [1:0] acc, hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int rq, input logic [3:0] u, input logic err);
        exp_t e;
        e.rq = rq; e.u = u; e.err = err;
        exp_q.push_back(e);
    endtask

    // One clock: drive requesters, score handshakes before the edge, observe after it.
    task automatic tick();
        exp_t e;
        req_valid[0] = (src0_q.size() > 0);
        req_y[0]     = (src0_q.size() > 0) ? to_llr(src0_q[0]) : '0;
        req_valid[1] = (src1_q.size() > 0);
        req_y[1]     = (src1_q.size() > 0) ? to_llr(src1_q[0]) : '0;
        #1;
        acc = req_ready & req_valid;
        hs  = rsp_valid & rsp_ready;
        if (acc != 2'b00) acc_cyc = cyc;
        if (hs != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(hs), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid_onehot", 32'(rsp_valid), 32'(2'b01 << e.rq));
                check("rsp_u", 32'(rsp_u), 32'(e.u));
                check("rsp_error", 32'(rsp_error), 32'(e.err));
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (acc[0]) void'(src0_q.pop_front());
        if (acc[1]) void'(src1_q.pop_front());
        if (dec_in_valid) begin
            pulses++;
            check("issue_one_after_accept", 32'(cyc), 32'(acc_cyc + 1));
        end
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, p0;
        rst = 1'b1; req_valid = '0; req_y = '0; req_frozen = '0; rsp_ready = '0;
        stub_en = 1'b1; force_vld = 1'b0; force_u = 4'h0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_dec_in_valid", 32'(dec_in_valid), 32'd0);
        check("rst_blk_count", 32'(blk_count), 32'd0);
        check("rst_rsp_u", 32'(rsp_u), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_dec_y", 32'(dec_y), 32'd0);
        check("rst_dec_frozen", 32'(dec_frozen), 32'd0);

        // Single block from requester 0
        rsp_ready = 2'b11;
        src0_q.push_back(4'b0101);
        push_exp(0, 4'b0101, 1'b0);
        p0 = pulses;
        drain("single_drain", 60);
        check("single_pulses", 32'(pulses - p0), 32'd1);
        check("single_blk_count", 32'(blk_count), 32'd1);

        // Contention from reset: strict alternation starting at requester 0
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_blk_count", 32'(blk_count), 32'd0);
        src0_q.push_back(4'b0011); src0_q.push_back(4'b1110);
        src1_q.push_back(4'b1001); src1_q.push_back(4'b0110);
        push_exp(0, 4'b0011, 1'b0);
        push_exp(1, 4'b1001, 1'b0);
        push_exp(0, 4'b1110, 1'b0);
        push_exp(1, 4'b0110, 1'b0);
        drain("contention_drain", 200);
        check("contention_blk_count", 32'(blk_count), 32'd4);

        // Backpressure on requester 1 while requester 0 waits
        rsp_ready = 2'b01;
        src1_q.push_back(4'b1101);
        push_exp(1, 4'b1101, 1'b0);
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 40) begin tick(); n++; end
        check("bp_rsp_seen", 32'(rsp_valid), 32'b10);
        src0_q.push_back(4'b0111);
        push_exp(0, 4'b0111, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'b10);
            check("bp_hold_u", 32'(rsp_u), 32'b1101);
            check("bp_no_ready", 32'(req_ready), 32'd0);
            check("bp_no_issue", 32'(dec_in_valid), 32'd0);
        end
        rsp_ready = 2'b11;
        drain("bp_drain", 60);
        check("bp_blk_count", 32'(blk_count), 32'd6);

        // Reset while waiting on a silent decoder, then a stale done
        stub_en = 1'b0;
        src0_q.push_back(4'b1100);
        p0 = pulses; n = 0;
        while (pulses == p0 && n < 20) begin tick(); n++; end
        check("rw_issued", 32'(pulses - p0), 32'd1);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        force_vld = 1'b1; force_u = 4'hF; tick(); force_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("rw_blk_count", 32'(blk_count), 32'd0);
        stub_en = 1'b1;
        src0_q.push_back(4'b1010); src1_q.push_back(4'b0001);
        push_exp(0, 4'b1010, 1'b0);
        push_exp(1, 4'b0001, 1'b0);
        drain("rw_drain", 100);
        check("rw_blk_after", 32'(blk_count), 32'd2);

        // Stray done while idle
        force_vld = 1'b1; force_u = 4'h6; tick(); force_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("stray_blk_count", 32'(blk_count), 32'd2);
        src0_q.push_back(4'b1000);
        push_exp(0, 4'b1000, 1'b0);
        drain("stray_drain", 60);
        check("stray_blk_after", 32'(blk_count), 32'd3);

`ifdef POLAR_SCHED_TIMEOUT_EN
        // Timeout with an unresponsive decoder
        stub_en = 1'b0;
        rsp_ready = 2'b00;
        src1_q.push_back(4'b1011);
        push_exp(1, 4'b0000, 1'b1);
        n = 0;
        while (rsp_valid === 2'b00 && n < 40) begin tick(); n++; end
        check("tmo_rsp_valid", 32'(rsp_valid), 32'b10);
        check("tmo_latency", 32'(cyc - acc_cyc), 32'd10);
        check("tmo_rsp_u", 32'(rsp_u), 32'd0);
        check("tmo_rsp_error", 32'(rsp_error), 32'd1);
        rsp_ready = 2'b11;
        drain("tmo_drain", 20);
        force_vld = 1'b1; force_u = 4'hB; tick(); force_vld = 1'b0;
        tick();
        check("tmo_late_ignored", 32'(rsp_valid), 32'd0);
        check("tmo_blk_count", 32'(blk_count), 32'd4);
        stub_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
